// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, select encodings and micro-op record for the ALU front end
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [1:0] {
    G_SEL_SUM = 2'b00,
    G_SEL_XOR = 2'b01,
    G_SEL_OR  = 2'b10,
    G_SEL_AND = 2'b11
  } g_sel_t;

  typedef struct packed {
    g_sel_t                 g_select;
    logic                   invert_b;
    logic                   carry_in;
    logic                   illegal;
    logic [ALU_XLEN-1:0]    op_a;
    logic [ALU_XLEN-1:0]    op_b;
    logic [ALU_TAG_W-1:0]   tag;
  } alu_uop_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// rtl/alu_skid_buffer.sv - 2-entry skid buffer; in_ready comes straight from a flop
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter type T = alu_uop_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic main_valid;
  logic skid_valid;
  T     main_data;
  T     skid_data;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      // Upstream is stalled while the skid entry is occupied; only draining happens.
      if (out_ready) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!main_valid || out_ready) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - OP/OP-IMM decode into ALU controls; ALU_CTRL_DECODER_PERF_EN adds issue counters
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_g_select,
  output logic             out_invert_b,
  output logic             out_carry_in,
  output logic [XLEN-1:0]  out_op_a,
  output logic [XLEN-1:0]  out_op_b,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_CTRL_DECODER_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_illegal,
`endif
  output logic             out_illegal
);

  alu_uop_t dec_uop;
  alu_uop_t held_uop;
  logic     is_op;
  logic     is_op_imm;

  assign is_op     = (in_opcode == OPC_OP);
  assign is_op_imm = (in_opcode == OPC_OP_IMM);

  always_comb begin
    dec_uop          = '0;
    dec_uop.op_a     = in_rs1;
    dec_uop.op_b     = is_op_imm ? in_imm : in_rs2;
    dec_uop.tag      = in_tag;
    dec_uop.g_select = G_SEL_SUM;
    if (!is_op && !is_op_imm) begin
      dec_uop.illegal = 1'b1;
    end else begin
      case (in_funct3)
        F3_ADD: begin
          // Only the register form encodes SUB; ADDI has no funct7 field.
          dec_uop.invert_b = is_op & in_funct7_b5;
          dec_uop.carry_in = is_op & in_funct7_b5;
        end
        F3_XOR:  dec_uop.g_select = G_SEL_XOR;
        F3_OR:   dec_uop.g_select = G_SEL_OR;
        F3_AND:  dec_uop.g_select = G_SEL_AND;
        default: dec_uop.illegal  = 1'b1;
      endcase
    end
  end

  alu_skid_buffer #(
    .T(alu_uop_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_uop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held_uop)
  );

  assign out_g_select = held_uop.g_select;
  assign out_invert_b = held_uop.invert_b;
  assign out_carry_in = held_uop.carry_in;
  assign out_illegal  = held_uop.illegal;
  assign out_op_a     = held_uop.op_a;
  assign out_op_b     = held_uop.op_b;
  assign out_tag      = held_uop.tag;

`ifdef ALU_CTRL_DECODER_PERF_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued  <= '0;
      perf_illegal <= '0;
    end else if (out_fire) begin
      perf_issued <= perf_issued + 32'd1;
      if (held_uop.illegal) begin
        perf_illegal <= perf_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
- Front end of the integer ALU. Accepts RISC-V OP/OP-IMM micro-ops from the decode stage over a valid/ready handshake.
- Decodes opcode/funct3/funct7 into the 2-bit result-select code (00 sum, 01 xor, 10 or, 11 and) plus adder controls, and selects operand B (rs2 or immediate).
- Outputs are registered through a 2-entry skid buffer so backpressure from the ALU/writeback never creates a combinational ready path.

Parameters:
- XLEN, 32, operand width.
- TAG_W, 5, width of destination-register tag carried alongside the op.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode stage presents an op.
- in_ready  output  1  block can accept an op this cycle.
- in_opcode  input  7  instruction[6:0].
- in_funct3  input  3  instruction[14:12].
- in_funct7_b5  input  1  instruction[30].
- in_rs1  input  XLEN  rs1 value.
- in_rs2  input  XLEN  rs2 value.
- in_imm  input  XLEN  sign-extended I-immediate.
- in_tag  input  TAG_W  destination register index.
- out_valid  output  1  decoded op available.
- out_ready  input  1  ALU accepts op.
- out_g_select  output  2  result-select code.
- out_invert_b  output  1  ALU inverts operand B.
- out_carry_in  output  1  adder carry-in.
- out_op_a  output  XLEN  operand A.
- out_op_b  output  XLEN  operand B, already muxed.
- out_tag  output  TAG_W  passthrough tag.
- out_illegal  output  1  op unsupported by this ALU; g_select forced 00.

Behaviour:
- Clocking: single clock, clk; rst_n asynchronous assert, synchronous deassert handled externally.
- Reset values: out_valid=0, in_ready=1, out_illegal=0; all data outputs 0; skid buffer empty.
- Transfers: input handshake on in_valid&&in_ready; output handshake on out_valid&&out_ready.
- Decode, combinational into storage:
  - opcode 0110011 (OP): op_b=rs2.
  - opcode 0010011 (OP-IMM): op_b=imm.
  - funct3 000 -> g_select 00. If OP and funct7_b5=1 (SUB): invert_b=1, carry_in=1; otherwise both 0. For OP-IMM, funct7_b5 is ignored (ADDI).
  - funct3 100 -> 01; 110 -> 10; 111 -> 11; invert_b=carry_in=0 for all three.
  - funct3 001/010/011/101 (shifts, SLT/SLTU), or any other opcode: illegal=1, g_select=00, invert_b=0, carry_in=0, operands still passed through.
  - op_a = rs1 always.
- Storage: main register (drives outputs) plus one skid register.
  - in_ready = skid register empty. in_ready is registered; it does not depend combinationally on out_ready.
  - Accept while main empty, or main full and out_ready=1: op loads into main.
  - Accept while main full and out_ready=0: op goes to skid; in_ready drops next cycle.
  - Output fires while skid full: skid moves to main; in_ready=1 next cycle.
  - Simultaneous accept and output fire with skid empty: new op replaces main; out_valid stays 1.
- Ordering and latency: strict FIFO order, no op lost or duplicated. Minimum latency 1 cycle (in accept at edge N, out_valid at N+1). Throughput 1 op/cycle when out_ready is held high.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Reset mid-operation: both entries are discarded; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro ALU_CTRL_DECODER_PERF_EN.
- Defined: adds output ports perf_issued[31:0] and perf_illegal[31:0].
  - perf_issued increments on each output handshake.
  - perf_illegal increments on each output handshake where out_illegal=1.
  - Both wrap modulo 2^32; reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - localparams OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011;
  - funct3 constants F3_ADD, F3_XOR, F3_OR, F3_AND;
  - G_SEL_SUM/XOR/OR/AND encodings 00/01/10/11;
  - packed struct alu_uop_t {g_select, invert_b, carry_in, illegal, op_a, op_b, tag}.
- One sub-module, alu_skid_buffer: generic 2-entry skid buffer over alu_uop_t. Decode logic stays in the top module.

Test Plan:
- Reset then OP funct3=000 funct7_b5=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, g_select=00, invert_b=1, carry_in=1, op_a=10, op_b=3.
- OP-IMM funct3=110, funct7_b5=1, imm=0xFFFFFFF0 -> g_select=10, invert_b=0, op_b=0xFFFFFFF0, illegal=0.
- OP funct3=001 (SLL), then opcode 0000011 (load) -> both emit illegal=1, g_select=00, in order.
- Hold out_ready=0, drive 3 back-to-back ops A, B, C:
  - A is held in main and B in skid; in_ready=0 after the second accept; C stays pending with all out_* stable.
  - Raise out_ready -> A, B, C emerge in order, one per cycle, no gaps.
- Random in_valid/out_ready over 10k ops with a scoreboard -> no loss, no duplication, order preserved. With PERF_EN, counters match the scoreboard counts.
- Assert rst_n=0 while both entries are full -> out_valid=0 and in_ready=1 immediately; after release the next op is decoded normally.
